// File: rtl/data_write_fifo.sv
// rtl/data_write_fifo.sv - in-order store buffer between commit and the memory write port
// Tracks occupancy with a count register so full/empty need no pointer-compare special cases.
module data_write_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] datafifo_addr_in,
  input  logic [31:0] datafifo_val_in,
  input  logic [1:0]  datafifo_size_in,
  input  logic        datafifo_valid_in,
  output logic        datafifo_full,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_val,
  output logic [1:0]  mem_wr_size,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  input  logic        mem_wr_access_fault,
  input  logic [31:0] lookup_addr,
  output logic        lookup_hit,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        empty
);

  logic [31:0]    addr_mem [DEPTH];
  logic [31:0]    val_mem  [DEPTH];
  logic [1:0]     size_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic           push;
  logic           pop;

  assign datafifo_full = (count == (PTR_W+1)'(DEPTH));
  assign empty         = (count == '0);
  assign mem_wr_valid  = ~empty;
  assign mem_wr_addr   = addr_mem[head];
  assign mem_wr_val    = val_mem[head];
  assign mem_wr_size   = size_mem[head];

  // Full is judged on registered count only; a same-cycle pop does not make room.
  assign push = datafifo_valid_in & ~datafifo_full;
  assign pop  = mem_wr_valid & mem_wr_ready;

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'd0;
  endfunction

  // Only occupied slots (head .. head+count-1) are searched; popped slots keep stale data.
  always_comb begin
    lookup_hit = push & same_word(datafifo_addr_in, lookup_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && same_word(addr_mem[head + PTR_W'(i)], lookup_addr))
        lookup_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_mem[tail] <= datafifo_addr_in;
      val_mem[tail]  <= datafifo_val_in;
      size_mem[tail] <= datafifo_size_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fault_valid <= 1'b0;
      fault_addr  <= 32'd0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (pop && !push)
        count <= count - (PTR_W+1)'(1);
      fault_valid <= pop & mem_wr_access_fault;
      if (pop && mem_wr_access_fault) fault_addr <= mem_wr_addr;
    end
  end

endmodule

// File: tb/tb_data_write_fifo.sv
// tb/tb_data_write_fifo.sv - directed self-checking bench for data_write_fifo
module tb_data_write_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] datafifo_addr_in;
  logic [31:0] datafifo_val_in;
  logic [1:0]  datafifo_size_in;
  logic        datafifo_valid_in;
  logic        datafifo_full;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_val;
  logic [1:0]  mem_wr_size;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic        mem_wr_access_fault;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        empty;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  data_write_fifo dut (
    .clk(clk), .reset(reset),
    .datafifo_addr_in(datafifo_addr_in), .datafifo_val_in(datafifo_val_in),
    .datafifo_size_in(datafifo_size_in), .datafifo_valid_in(datafifo_valid_in),
    .datafifo_full(datafifo_full),
    .mem_wr_addr(mem_wr_addr), .mem_wr_val(mem_wr_val), .mem_wr_size(mem_wr_size),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_access_fault(mem_wr_access_fault),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    datafifo_valid_in = v;
    datafifo_addr_in  = a;
    datafifo_val_in   = d;
    datafifo_size_in  = s;
  endtask

  logic [31:0] exp_q[$];
  int          cnt;
  int          pushed;
  int          popped;
  logic        do_push;
  logic        do_pop;

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    mem_wr_ready = 1'b0;
    mem_wr_access_fault = 1'b0;
    lookup_addr = 32'hFFFF_FFF0;
    step(); step();
    reset = 1'b0;
    #1;
    check("reset_full", {31'd0, datafifo_full}, 32'd0);
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_valid", {31'd0, mem_wr_valid}, 32'd0);
    check("reset_hit", {31'd0, lookup_hit}, 32'd0);
    check("reset_fault_valid", {31'd0, fault_valid}, 32'd0);
    check("reset_fault_addr", fault_addr, 32'd0);

    // single store, ready held high
    mem_wr_ready = 1'b1;
    drive(1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    check("single_valid", {31'd0, mem_wr_valid}, 32'd1);
    check("single_addr", mem_wr_addr, 32'h100);
    check("single_val", mem_wr_val, 32'hDEAD_BEEF);
    check("single_size", {30'd0, mem_wr_size}, 32'd2);
    step();
    check("single_empty", {31'd0, empty}, 32'd1);

    // fill with backpressure
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("fill_not_full", {31'd0, datafifo_full}, 32'd0);
      drive(1'b1, 32'h10 + 32'(4*k), 32'hA000 + 32'(k), 2'b10);
      step();
    end
    check("fill_full", {31'd0, datafifo_full}, 32'd1);
    drive(1'b1, 32'h20, 32'hBAD, 2'b10);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check("fill_still_full", {31'd0, datafifo_full}, 32'd1);
    mem_wr_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("drain_addr", mem_wr_addr, 32'h10 + 32'(4*k));
      check("drain_val", mem_wr_val, 32'hA000 + 32'(k));
      step();
    end
    check("drain_empty_no_fifth", {31'd0, empty}, 32'd1);

    // full with simultaneous pop: push refused
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h30 + 32'(4*k), 32'hB000 + 32'(k), 2'b10);
      step();
    end
    drive(1'b1, 32'h40, 32'hC040, 2'b10);
    mem_wr_ready = 1'b1;
    step();
    check("fullpop_not_full", {31'd0, datafifo_full}, 32'd0);
    check("fullpop_head", mem_wr_addr, 32'h34);
    mem_wr_ready = 1'b0;
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check("fullpop_reaccept_full", {31'd0, datafifo_full}, 32'd1);
    mem_wr_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("fullpop_order", mem_wr_addr, 32'h34 + 32'(4*k));
      step();
    end
    check("fullpop_empty", {31'd0, empty}, 32'd1);

    // wrap-around stream of 10 with ready toggling
    cnt = 0; pushed = 0; popped = 0;
    for (int c = 0; c < 60 && popped < 10; c++) begin
      mem_wr_ready = (c % 2 == 0);
      do_push = (pushed < 10) && (cnt < 4);
      if (do_push)
        drive(1'b1, 32'h1000 + 32'(8*pushed), 32'h5A00_0000 + 32'(pushed), 2'(pushed));
      else
        drive(1'b0, 32'd0, 32'd0, 2'b00);
      #1;
      check("wrap_full", {31'd0, datafifo_full}, {31'd0, cnt == 4});
      check("wrap_valid", {31'd0, mem_wr_valid}, {31'd0, cnt > 0});
      do_pop = mem_wr_ready && (cnt > 0);
      if (do_pop) begin
        check("wrap_addr", mem_wr_addr, 32'h1000 + 32'(8*popped));
        check("wrap_val", mem_wr_val, 32'h5A00_0000 + 32'(popped));
        check("wrap_size", {30'd0, mem_wr_size}, {30'd0, 2'(popped)});
        popped++;
        cnt--;
      end
      if (do_push) begin
        pushed++;
        cnt++;
      end
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    check("wrap_count", 32'(popped), 32'd10);
    check("wrap_empty", {31'd0, empty}, 32'd1);

    // lookup
    mem_wr_ready = 1'b0;
    drive(1'b1, 32'h203, 32'hEE, 2'b00);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    lookup_addr = 32'h200;
    #1;
    check("lookup_same_word", {31'd0, lookup_hit}, 32'd1);
    lookup_addr = 32'h204;
    #1;
    check("lookup_next_word", {31'd0, lookup_hit}, 32'd0);
    lookup_addr = 32'h306;
    drive(1'b1, 32'h304, 32'h11, 2'b01);
    #1;
    check("lookup_incoming", {31'd0, lookup_hit}, 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    #1;
    check("lookup_buffered_second", {31'd0, lookup_hit}, 32'd1);
    mem_wr_ready = 1'b1;
    step(); step();
    lookup_addr = 32'h200;
    #1;
    check("lookup_drained_empty", {31'd0, empty}, 32'd1);
    check("lookup_stale_miss", {31'd0, lookup_hit}, 32'd0);

    // fault
    mem_wr_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h55, 2'b10);
    step();
    drive(1'b1, 32'h504, 32'h66, 2'b10);
    step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    mem_wr_ready = 1'b1;
    mem_wr_access_fault = 1'b1;
    step();
    mem_wr_access_fault = 1'b0;
    check("fault_pulse", {31'd0, fault_valid}, 32'd1);
    check("fault_addr", fault_addr, 32'h500);
    check("fault_next_head", mem_wr_addr, 32'h504);
    step();
    check("fault_pulse_end", {31'd0, fault_valid}, 32'd0);
    check("fault_addr_hold", fault_addr, 32'h500);
    check("fault_drained", {31'd0, empty}, 32'd1);
    mem_wr_access_fault = 1'b1;
    step();
    mem_wr_access_fault = 1'b0;
    check("fault_without_pop", {31'd0, fault_valid}, 32'd0);

    // reset drops buffered stores
    mem_wr_ready = 1'b0;
    drive(1'b1, 32'h600, 32'h1, 2'b10);
    step(); step();
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("reset_mid_empty", {31'd0, empty}, 32'd1);
    check("reset_mid_fault_addr", fault_addr, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_write_fifo.md
# data_write_fifo

Store buffer on the far side of the pipeline's data-bus write port. It accepts committed stores (`datafifo_*`) from the commit stage, holds them in order, and drains them one at a time to the memory write port with a valid/ready handshake. It also reports whether any buffered store overlaps a load address, so the load path can stall instead of reading stale memory. It reports write access faults back to the core.

## Interface

Parameters:
- `DEPTH`, default 4: number of store entries; must be a power of two, at least 2.
- `PTR_W`, default `$clog2(DEPTH)`: width of the head and tail pointers.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `datafifo_addr_in`, input, 32: store byte address from commit.
- `datafifo_val_in`, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `datafifo_size_in`, input, 2: 00 byte, 01 half, 10 word, 11 reserved (stored and forwarded unchanged).
- `datafifo_valid_in`, input, 1: push request.
- `datafifo_full`, output, 1: buffer cannot accept a push this cycle.
- `mem_wr_addr`, output, 32: address of the head entry.
- `mem_wr_val`, output, 32: data of the head entry.
- `mem_wr_size`, output, 2: size of the head entry.
- `mem_wr_valid`, output, 1: the head entry is valid.
- `mem_wr_ready`, input, 1: memory accepts the head entry this cycle.
- `mem_wr_access_fault`, input, 1: qualifies `mem_wr_ready`; the accepted write faulted.
- `lookup_addr`, input, 32: load address to check against buffered stores.
- `lookup_hit`, output, 1: a buffered or incoming store covers the same 32-bit word.
- `fault_valid`, output, 1: one-cycle pulse reporting a faulted write.
- `fault_addr`, output, 32: address of the faulted write; holds its value until the next fault.
- `empty`, output, 1: no entries are buffered.

## Operation

Storage:
- `DEPTH` entries, each holding {addr, val, size}.
- Registered `head` and `tail` pointers (`PTR_W` bits, natural wrap) plus a `count` register (0..DEPTH).

Push:
- `push = datafifo_valid_in & ~datafifo_full`.
- Writes the entry at `tail` and increments `tail`.
- A valid while full is ignored (not stored); commit must hold the store until full drops.

Pop:
- `pop = mem_wr_valid & mem_wr_ready`.
- Increments `head`, with or without a fault.

Count:
- `count` updates by +1 on push only, −1 on pop only, and is unchanged when both occur.

Derived outputs (combinational from registered state):
- `datafifo_full = (count == DEPTH)`. This is not relieved by a same-cycle pop: a push while full is refused even if a pop occurs that cycle.
- `empty = (count == 0)` and `mem_wr_valid = ~empty`.
- `mem_wr_addr`, `mem_wr_val` and `mem_wr_size` are the fields of entry `head`. They are stable while valid and not ready.

Fault:
- When `pop & mem_wr_access_fault`, the next cycle drives `fault_valid = 1` and `fault_addr = mem_wr_addr` of the popped entry.
- `fault_valid` is 0 in every other cycle.
- The entry is discarded; draining continues.
- `mem_wr_access_fault` without `pop` is ignored.

Lookup:
- `lookup_hit = 1` if any entry i among the `count` occupied entries has `addr[31:2] == lookup_addr[31:2]`, or if `push` is asserted and `datafifo_addr_in[31:2] == lookup_addr[31:2]`.
- Matching is word-granular and conservative; size is ignored.
- The head entry being popped this cycle still counts as a hit.

Reset:
- `head`, `tail`, `count`, `fault_valid` and `fault_addr` are cleared to 0.
- Entry storage is not cleared.
- Reset overrides any push, pop or fault in the same cycle; buffered stores are lost.

## Timing

- Reset values: `datafifo_full = 0`, `empty = 1`, `mem_wr_valid = 0`, `lookup_hit = 0` (when `datafifo_valid_in = 0`), `fault_valid = 0`, `fault_addr = 0`.
- `mem_wr_addr`, `mem_wr_val` and `mem_wr_size` are don't-care while `mem_wr_valid = 0`.
- Push-to-memory latency: a store pushed at edge N appears on `mem_wr_*` in cycle N+1. With `mem_wr_ready` high, it pops at edge N+1.
- Throughput: one push and one pop per cycle sustained when not full.
- Fault report: `fault_valid` is asserted the cycle after the faulting pop edge.
- `lookup_hit` is combinational, with the same-cycle push path included.
- Pointer wrap: after `DEPTH` pushes, `tail` returns to 0 with no special case.

## Test plan

- **Reset and single store.** After reset, push addr 0x100, val 0xDEADBEEF, size 10 with ready=1 → next cycle `mem_wr_valid = 1` with those fields; it pops at that edge; `empty = 1` one cycle later.
- **Fill and backpressure.** Hold ready=0 and push 4 stores (0x10, 0x14, 0x18, 0x1C) → `datafifo_full = 1` after the 4th. A 5th valid (0x20) is not stored. Raise ready → writes appear in order 0x10, 0x14, 0x18, 0x1C, one per cycle.
- **Full with simultaneous pop.** With the buffer full, ready=1 and valid=1 (0x40) in the same cycle → the head pops, 0x40 is refused, and count becomes 3. Re-presenting 0x40 next cycle is accepted.
- **Wrap-around.** Stream 10 stores with ready toggling 1,0,1,0,… → all 10 emerge in order with unchanged data; count never exceeds 4.
- **Lookup.** Buffer holds 0x203 (byte). `lookup_addr = 0x200` → hit=1; `lookup_addr = 0x204` → hit=0. Pushing 0x304 while `lookup_addr = 0x306` → hit=1 in the same cycle.
- **Fault.** Pop 0x500 with `mem_wr_access_fault = 1` → next cycle `fault_valid = 1` and `fault_addr = 0x500`; the following entry drains normally; `fault_valid` is 0 a cycle later and `fault_addr` holds 0x500.
